// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: state encoding and default operand width for the serial adder
package serial_add_ctrl_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: 1-bit full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract, LSB first, one bit per clock through a single full adder
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t st, nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-2:0] sh;
  logic [WIDTH-1:0] nsh;
  logic [CW-1:0] cnt;
  logic sub_r, c, fa_s, fa_c, last;
  fa_cell u_fa (
    .a   (a_r[cnt]),
    .b   (b_r[cnt] ^ sub_r),
    .cin (c),
    .sum (fa_s),
    .cout(fa_c)
  );
  // nsh is the result with the bit being processed this cycle shifted in at the top
  assign nsh  = {fa_s, sh};
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nx;
  always_comb begin
    nx   = st == IDLE ? (start ? RUN : IDLE) : st == RUN ? (last ? DONE : RUN) : IDLE;
    busy = st != IDLE;
    done = st == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      sub_r <= 1'b0;
      c     <= 1'b0;
      cnt   <= '0;
      sh    <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (st == IDLE && start) begin
      a_r   <= a;
      b_r   <= b;
      sub_r <= sub;
      c     <= sub;
      cnt   <= '0;
    end else if (st == RUN) begin
      sh  <= nsh[WIDTH-1:1];
      c   <= fa_c;
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) begin
        sum  <= nsh;
        cout <= fa_c;
        ovf  <= c ^ fa_c;
      end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and randomized checks of serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic sub = 1'b0;
  logic busy, done, cout, ovf;
  logic [7:0] sum;
  int n_cmp = 0, n_err = 0;
  int lat, n_done, last_done, idle_cnt;
  logic [9:0] exp_v, prev_v;
  logic [16:0] q[$];
  logic [16:0] op;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial forever #5 clk = ~clk;

  // returns {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    int r;
    logic [7:0] rs;
    logic co, ov;
    r  = s ? int'(x) + 256 - int'(y) : int'(x) + int'(y);
    rs = r[7:0];
    co = s ? (x >= y) : (r > 255);
    ov = s ? (x[7] != y[7] && rs[7] != x[7]) : (x[7] == y[7] && rs[7] != x[7]);
    return {ov, co, rs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [9:0] e;
    int l;
    e = model(x, y, s);
    @(negedge clk);
    start = 1'b1; a = x; b = y; sub = s;
    @(posedge clk);
    #1 start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    chk("busy_after_accept", 32'(busy), 32'(1));
    l = 0;
    while (!done && l < 20) begin
      @(posedge clk);
      #1 l++;
    end
    chk("done_latency", 32'(l), 32'(8));
    chk("result", 32'({ovf, cout, sum}), 32'(e));
    @(posedge clk);
    #1 chk("idle_after_done", 32'({busy, done}), 32'(0));
    prev_v = e;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 chk("reset_outputs", 32'({busy, done, cout, ovf, sum}), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    do_op(8'h0F, 8'h01, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'h05, 8'h07, 1'b1);
    do_op(8'h80, 8'h01, 1'b1);
    // second start during RUN must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20; sub = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("sum_held_in_run", 32'({ovf, cout, sum}), 32'(prev_v));
    start = 1'b1; a = 8'h55; b = 8'h66; sub = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (done) n_done++;
    end
    chk("ignored_start_done_count", 32'(n_done), 32'(1));
    chk("ignored_start_result", 32'({ovf, cout, sum}), 32'(model(8'h10, 8'h20, 1'b0)));
    // reset mid-RUN abandons the operation
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h11; sub = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'({busy, done, cout, ovf, sum}), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (done) n_done++;
    end
    chk("no_done_after_reset", 32'(n_done), 32'(0));
    do_op(8'h03, 8'h04, 1'b0);
    for (int i = 0; i < 12; i++) do_op(8'($urandom), 8'($urandom), 1'($urandom));
    // start held high: operands sampled in each idle cycle are queued for the model
    n_done = 0; last_done = -1; idle_cnt = 0;
    start = 1'b1;
    for (int cyc = 0; cyc < 100 && n_done < 6; cyc++) begin
      @(negedge clk);
      if (done) begin
        op = q.pop_front();
        chk("stream_result", 32'({ovf, cout, sum}), 32'(model(op[16:9], op[8:1], op[0])));
        if (last_done >= 0) begin
          chk("stream_period", 32'(cyc - last_done), 32'(10));
          chk("stream_idle_cycles", 32'(idle_cnt), 32'(1));
        end
        last_done = cyc; idle_cnt = 0; n_done++;
      end
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      if (!busy) begin
        idle_cnt++;
        q.push_back({a, b, sub});
      end
    end
    chk("stream_done_count", 32'(n_done), 32'(6));
    start = 1'b0;
    repeat (12) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request to begin one operation.
REQ-005 The block SHALL have port a  input  WIDTH  operand A, sampled only on the start-accept edge.
REQ-006 The block SHALL have port b  input  WIDTH  operand B, sampled only on the start-accept edge.
REQ-007 The block SHALL have port sub  input  1  0 = A+B, 1 = A-B, sampled only on the start-accept edge.
REQ-008 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum  output  WIDTH  result register.
REQ-011 The block SHALL have port cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-012 The block SHALL have port ovf  output  1  signed two's-complement overflow.

Function
REQ-013 The block SHALL compute the result bit-serially, LSB first, one bit per clock, through a single 1-bit full-adder cell and a carry flip-flop.
REQ-014 The block SHALL implement states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch a, b and sub, set the carry flip-flop to sub, clear the bit counter, and enter RUN on that edge.
REQ-016 In subtract mode, the block SHALL feed the inverted B bit to the full-adder cell.
REQ-017 In RUN, each edge SHALL process bit[cnt], shift the result bit into an internal shift register, update the carry, and increment cnt.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1, the block SHALL enter DONE.
REQ-019 On entry to DONE, the block SHALL load sum, cout and ovf, where ovf = (carry into MSB) XOR (carry out of MSB).
REQ-020 done SHALL be high for exactly the one cycle spent in DONE, beginning WIDTH rising edges after the start-accept edge; DONE SHALL then return to IDLE unconditionally.
REQ-021 start SHALL be ignored in RUN and DONE; no queuing, and latched operands SHALL be unaffected.
REQ-022 sum, cout and ovf SHALL hold their values from DONE until the next DONE; they SHALL NOT change during RUN.
REQ-023 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle following DONE, giving a throughput of one result per WIDTH+2 cycles.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap during a legal operation.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE and clear busy, done, sum, cout, ovf, the carry flip-flop, the counter and the shift register to 0, independent of clk.
REQ-026 Reset asserted mid-RUN SHALL abandon the operation; no done pulse SHALL follow, and the next start after release SHALL be accepted normally.
REQ-027 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Structure
REQ-028 A shared package SHALL hold the state encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the WIDTH default.
REQ-029 The 1-bit full-adder SHALL be a sub-module named fa_cell (a, b, cin -> sum, cout), instantiated exactly once.
REQ-030 Unused state encoding 2'b11 SHALL transition to IDLE.

Verification (WIDTH=8)
REQ-031 The bench SHALL cover: a=0x0F, b=0x01, sub=0 -> sum=0x10, cout=0, ovf=0; done exactly 8 edges after the start-accept edge.
REQ-032 The bench SHALL cover: a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, ovf=1; a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0.
REQ-033 The bench SHALL cover: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-034 The bench SHALL cover: start pulsed again with new operands during RUN -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-035 The bench SHALL cover: rst_n pulled low at RUN cycle 4 -> all outputs 0 immediately and no done pulse; a new start after release (0x03+0x04) -> sum=0x07.
REQ-036 The bench SHALL cover: start held high continuously -> done pulses every 10 cycles; busy is low for exactly one cycle between operations.
